// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 dot-product sequencer and its bench.
// OPMODE encodings, state enum and default widths.
package dsp_pkg;

    localparam int DEF_WIDTH_1 = 8;
    localparam int DEF_WIDTH_2 = 18;
    localparam int DEF_WIDTH_4 = 48;
    localparam int DEF_DSP_LAT = 3;
    localparam int DEF_OPMODE_LAG = 1;
    localparam int DEF_MAX_LEN = 1024;

    // X=M Z=0 / X=M Z=P; a bubble is ACC with zero operands
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC = 8'h09;
    localparam logic [7:0] OPM_BUBBLE = 8'h09;
    localparam logic [7:0] OPM_IDLE = 8'h08;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    function automatic logic [7:0] opm_term(input logic first);
        return first ? OPM_FIRST : OPM_ACC;
    endfunction

endpackage

// File: rtl/dsp_opmode_delay.sv
// OPMODE delay line: DEPTH-deep shift register with synchronous reset value.
// Keeps OPMODE trailing the operands to match the slice register stages.
module dsp_opmode_delay
    import dsp_pkg::*;
#(
    parameter int W = DEF_WIDTH_1,
    parameter int DEPTH = DEF_OPMODE_LAG,
    parameter logic [W-1:0] RST_VAL = W'(OPM_BUBBLE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] opmode,
    output logic [W-1:0] delayed
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= opmode;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/dsp_dotp_sequencer.sv
// Operand sequencer feeding a DSP48A1 MAC slice and capturing its P result.
// Optional DOTP_TERM_COUNT_EN adds m_count / m_len_err term accounting.
module dsp_dotp_sequencer
    import dsp_pkg::*;
#(
    parameter int WIDTH_2 = DEF_WIDTH_2,
    parameter int WIDTH_4 = DEF_WIDTH_4,
    parameter int WIDTH_1 = DEF_WIDTH_1,
    parameter int DSP_LAT = DEF_DSP_LAT,
    parameter int OPMODE_LAG = DEF_OPMODE_LAG,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH_2-1:0] s_a,
    input  logic [WIDTH_2-1:0] s_b,
    input  logic               s_last,
    output logic [WIDTH_2-1:0] dsp_a,
    output logic [WIDTH_2-1:0] dsp_b,
    output logic [WIDTH_1-1:0] dsp_opmode,
    input  logic [WIDTH_4-1:0] dsp_p,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH_4-1:0] m_result,
`ifdef DOTP_TERM_COUNT_EN
    output logic [$clog2(MAX_LEN+1):0] m_count,
    output logic               m_len_err,
`endif
    output logic               busy
);

    localparam int CNT_W = $clog2(DSP_LAT + 1);

    if (OPMODE_LAG < 1 || OPMODE_LAG >= DSP_LAT || MAX_LEN < 1) begin : g_bad_cfg
        $error("dsp_dotp_sequencer: invalid configuration");
    end

    state_t             state, state_nxt;
    logic               first_pending, first_nxt;
    logic [CNT_W-1:0]   drain, drain_nxt;
    logic [WIDTH_2-1:0] a_nxt, b_nxt;
    logic [WIDTH_1-1:0] opm_push, opm_tail;
    logic [WIDTH_4-1:0] result_nxt;
    logic               valid_nxt;
    logic               hs;
    logic               capture;

    assign s_ready = (state == ACCUM);
    assign hs = s_valid & s_ready;
    assign busy = !((state == ACCUM) && first_pending);

    always_comb begin
        state_nxt = state;
        first_nxt = first_pending;
        drain_nxt = drain;
        a_nxt = '0;
        b_nxt = '0;
        opm_push = WIDTH_1'(OPM_BUBBLE);
        result_nxt = m_result;
        valid_nxt = m_valid;
        capture = 1'b0;
        unique case (state)
            ACCUM: begin
                if (hs) begin
                    a_nxt = s_a;
                    b_nxt = s_b;
                    opm_push = WIDTH_1'(opm_term(first_pending));
                    first_nxt = 1'b0;
                    if (s_last) begin
                        drain_nxt = CNT_W'(DSP_LAT);
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain == '0) begin
                    result_nxt = dsp_p;
                    valid_nxt = 1'b1;
                    capture = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    drain_nxt = drain - CNT_W'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    valid_nxt = 1'b0;
                    first_nxt = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ACCUM;
            first_pending <= 1'b1;
            drain <= '0;
            dsp_a <= '0;
            dsp_b <= '0;
            dsp_opmode <= WIDTH_1'(OPM_IDLE);
            m_valid <= 1'b0;
            m_result <= '0;
        end else begin
            state <= state_nxt;
            first_pending <= first_nxt;
            drain <= drain_nxt;
            dsp_a <= a_nxt;
            dsp_b <= b_nxt;
            dsp_opmode <= opm_tail;
            m_valid <= valid_nxt;
            m_result <= result_nxt;
        end
    end

    // The output register above adds one stage after the delay line.
    dsp_opmode_delay #(
        .W(WIDTH_1),
        .DEPTH(OPMODE_LAG),
        .RST_VAL(WIDTH_1'(OPM_IDLE))
    ) u_opm_delay (
        .clk(CLK),
        .rst(RST),
        .opmode(opm_push),
        .delayed(opm_tail)
    );

`ifdef DOTP_TERM_COUNT_EN
    localparam int TW = $clog2(MAX_LEN + 1) + 1;

    logic [TW-1:0] terms;

    always_ff @(posedge CLK) begin
        if (RST) begin
            terms <= '0;
            m_count <= '0;
            m_len_err <= 1'b0;
        end else begin
            if (hs) begin
                if (first_pending) terms <= TW'(1);
                else if (terms != '1) terms <= terms + TW'(1);
            end
            if (capture) begin
                m_count <= terms;
                m_len_err <= (terms > TW'(MAX_LEN));
            end else if (state == HOLD && m_ready) begin
                m_len_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_dotp_sequencer.sv
// Bench for dsp_dotp_sequencer with a behavioural DSP48A1 slice model.
// Build with DOTP_TERM_COUNT_EN to exercise the term-count outputs.
module tb_dsp_dotp_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] s_a = '0;
    logic [17:0] s_b = '0;
    logic        s_last = 1'b0;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [47:0] m_result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];

    always #5 CLK = ~CLK;

`ifdef DOTP_TERM_COUNT_EN
    logic [3:0] m_count;
    logic       m_len_err;
    logic [3:0] cnt_q[$];
    logic       err_q[$];

    dsp_dotp_sequencer #(.MAX_LEN(4)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .dsp_a(dsp_a), .dsp_b(dsp_b),
        .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result),
        .m_count(m_count), .m_len_err(m_len_err),
        .busy(busy)
    );
`else
    dsp_dotp_sequencer dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .dsp_a(dsp_a), .dsp_b(dsp_b),
        .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result),
        .busy(busy)
    );
`endif

    // Slice model: A1/B1 -> M -> P, OPMODE registered once.
    logic signed [17:0] a1, b1;
    logic signed [35:0] mreg;
    logic [7:0]  opr;
    logic [47:0] preg, xsel, zsel;

    always_comb begin
        xsel = '0;
        zsel = '0;
        if (opr[1:0] == 2'b01) xsel = {{12{mreg[35]}}, mreg};
        if (opr[3:2] == 2'b10) zsel = preg;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a1 <= '0;
            b1 <= '0;
            mreg <= '0;
            opr <= 8'h08;
            preg <= '0;
        end else begin
            a1 <= dsp_a;
            b1 <= dsp_b;
            mreg <= a1 * b1;
            opr <= dsp_opmode;
            preg <= xsel + zsel;
        end
    end
    assign dsp_p = preg;

    // Scoreboard: one pop per result handshake.
    always @(negedge CLK) begin
        if (!RST && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: result %0d, none expected", m_result);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if (m_result !== e) begin
                    n_bad++;
                    $display("FAIL sb_result: got %0d, want %0d", m_result, e);
                end
            end
`ifdef DOTP_TERM_COUNT_EN
            if (cnt_q.size() != 0) begin
                logic [3:0] ec;
                logic ee;
                ec = cnt_q.pop_front();
                ee = err_q.pop_front();
                n_cmp++;
                if (m_count !== ec || m_len_err !== ee) begin
                    n_bad++;
                    $display("FAIL sb_count: got %0d/%0b, want %0d/%0b", m_count, m_len_err, ec, ee);
                end
            end
`endif
        end
    end

    task automatic send_term(input logic [17:0] a, input logic [17:0] b, input logic last);
        int w;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_last = last;
        w = 0;
        @(negedge CLK);
        while (!s_ready && w < 100) begin
            w++;
            @(negedge CLK);
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_ready %0b, want 1", s_ready);
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_a = '0;
        s_b = '0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 80) begin
            w++;
            @(posedge CLK);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending, want 0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_result !== 48'd0) begin n_bad++; $display("FAIL rst_m_result: got %0d want 0", m_result); end
        n_cmp++; if (dsp_a !== 18'd0) begin n_bad++; $display("FAIL rst_dsp_a: got %0d want 0", dsp_a); end
        n_cmp++; if (dsp_b !== 18'd0) begin n_bad++; $display("FAIL rst_dsp_b: got %0d want 0", dsp_b); end
        n_cmp++; if (dsp_opmode !== 8'h08) begin n_bad++; $display("FAIL rst_opmode: got %h want 08", dsp_opmode); end
    endtask

    task automatic test_basic();
        int n;
        m_ready = 1'b1;
        exp_q.push_back(48'd68);
        send_term(18'd2, 18'd3, 1'b0);
        send_term(18'd4, 18'd5, 1'b0);
        send_term(18'd6, 18'd7, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        n = 0;
        while (n < 20) begin
            @(posedge CLK);
            #1;
            n++;
            if (m_valid) break;
        end
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL basic_latency: got %0d edges want 4", n); end
        @(posedge CLK);
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: m_valid %b want 0", m_valid); end
        wait_drain();
    endtask

    task automatic test_gaps();
        exp_q.push_back(48'd68);
        send_term(18'd2, 18'd3, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        send_term(18'd4, 18'd5, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        send_term(18'd6, 18'd7, 1'b1);
        wait_drain();
    endtask

    task automatic test_single();
        exp_q.push_back(48'h493E0);
        send_term(18'd100000, 18'd3, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        m_ready = 1'b0;
        exp_q.push_back(48'd5);
        send_term(18'd1, 18'd1, 1'b0);
        send_term(18'd2, 18'd2, 1'b1);
        w = 0;
        while (!m_valid && w < 20) begin
            @(posedge CLK);
            #1;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_result !== 48'd5) begin
                n_bad++;
                $display("FAIL b2b_hold: v=%b rdy=%b res=%0d want 1/0/5", m_valid, s_ready, m_result);
            end
        end
        @(posedge CLK);
        #1;
        m_ready = 1'b1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_early: got %b want 0", s_ready); end
        @(posedge CLK);
        #1;
        n_cmp++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_release: rdy=%b v=%b want 1/0", s_ready, m_valid); end
        exp_q.push_back(48'd100);
        send_term(18'd10, 18'd10, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_drain();
        logic seen;
        send_term(18'd9, 18'd9, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rd_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rd_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (dsp_opmode !== 8'h08) begin n_bad++; $display("FAIL rd_opmode: got %h want 08", dsp_opmode); end
        n_cmp++; if (m_result !== 48'd0) begin n_bad++; $display("FAIL rd_m_result: got %0d want 0", m_result); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (m_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rd_no_result: m_valid seen %b want 0", seen); end
        @(posedge CLK);
        #1;
        exp_q.push_back(48'd12);
        send_term(18'd3, 18'd4, 1'b1);
        wait_drain();
    endtask

`ifdef DOTP_TERM_COUNT_EN
    task automatic test_term_count();
        exp_q.push_back(48'd5);
        cnt_q.push_back(4'd5);
        err_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) send_term(18'd1, 18'd1, i == 4);
        wait_drain();
        exp_q.push_back(48'd4);
        cnt_q.push_back(4'd4);
        err_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) send_term(18'd1, 18'd1, i == 3);
        wait_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_single();
        test_back_to_back();
        test_reset_drain();
`ifdef DOTP_TERM_COUNT_EN
        test_term_count();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
